reglist_sequencer: RTL and testbench
====================================

# reglist_sequencer

Parametrised register-list sequencer for block-transfer instructions (LDM/STM). Captures an N-bit register list, then emits one register per accepted beat, as both a binary index and a one-hot select, in ascending or descending order, with a ready/valid handshake towards the register-file/memory stage. It extends the fixed 4-to-16 one-hot decode with priority selection, ordering, stall handling and a transfer count.

## Interface
Parameters:
- NREGS, 16, number of registers in the list (power of 2, ≥ 2)
- IDXW, $clog2(NREGS), index width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  load reg_list/up; honoured only in IDLE
- reg_list  in  NREGS  register list, bit i = register i
- up  in  1  1 = ascending (lowest first), 0 = descending
- flush  in  1  synchronous abort, any state
- ready  in  1  downstream accepts the current beat
- valid  out  1  idx/onehot/last are meaningful
- idx  out  IDXW  register number of the current beat
- onehot  out  NREGS  decode of idx, all-zero when valid=0
- last  out  1  current beat is the final one
- count  out  IDXW+1  popcount of the captured list; held until next start
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the sequence completes

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: on start=1, capture pending ← reg_list, dir ← up, count ← popcount(reg_list).
  - Non-empty list → RUN, with first beat presented: valid=1, idx = lowest set bit (up=1) or highest set bit (up=0).
  - Empty list → DONE: count=0, valid never asserts.
- RUN: beat accepted when valid&ready. On acceptance, clear the selected bit in pending and select the next bit in the same direction.
  - last=1 when exactly one bit remains pending.
  - Accepting with last=1 → DONE, valid=0.
  - ready=0 → idx/onehot/last hold stable; pending unchanged.
- DONE: done=1 for exactly one cycle, then → IDLE.
- start outside IDLE, including the DONE cycle, is ignored. reg_list is sampled only on the accepted start.
- flush=1 → IDLE next cycle from any state. Clears pending, valid, last and done; no done pulse. count holds. flush has priority over start and ready.
- Reset (rst_n=0 at a clock edge): state=IDLE, valid=0, idx=0, onehot=0, last=0, count=0, busy=0, done=0, pending=0. Reset mid-sequence abandons the sequence with no done pulse.
- onehot is always the decode of idx ANDed with valid, so at most one bit is set.

## Timing
- start accepted at edge T → valid=1 with the first idx from edge T+1. Empty list → done=1 from edge T+1.
- Throughput: one beat per cycle while ready=1. A k-register list with ready held high produces beats during cycles T+1..T+k, done at T+k+1, and busy=0 / next start accepted at T+k+2.
- Minimum start-to-start period is k+2 cycles (2 for an empty list).
- busy is 1 in RUN and DONE.

## Structure
- Shared package `reglist_pkg`: state enum (IDLE/RUN/DONE), plus combinational functions `pri_lo(mask)` and `pri_hi(mask)` that return an index, and `popcnt(mask)`.
- One sub-module, `decoder_onehot #(.W(IDXW))`: parametrised binary-to-one-hot decoder with enable, the generalised successor of the 4-to-16 decoder. It drives onehot from idx, enabled by valid.
- The sequencer holds the state register, pending mask, direction flag and count register.

## Test plan
- reg_list=0x8001, up=1, ready=1 → beats idx 0 then 15, onehot 0x0001 then 0x8000, last on the second beat, count=2, done at T+3.
- reg_list=0x00F0, up=0, ready toggled 1,0,0,1,1,1 → idx 7,6,6,6,5,4. Outputs stable while stalled; last with idx 4; count=4.
- reg_list=0x0000 → no valid, done=1 at T+1, count=0, busy=0 at T+2.
- reg_list=0xFFFF, up=1, ready=1 → idx 0..15 consecutively, count=16, done at T+17. A start at T+5 with a different list is ignored.
- flush during the third beat of 0x0F0F → next cycle valid=0, busy=0, no done. A new start of 0x0002 one cycle later yields idx 1.
- rst_n=0 mid-sequence for one cycle → all outputs at reset values on the following cycle; no done pulse.
- NREGS=8 instance, reg_list=0xA5, up=0 → idx 7,5,2,0, count=4.

Source files
------------

// File: rtl/reglist_pkg.sv
// Shared types and helpers for the register-list sequencer: state encoding,
// priority pickers (lowest / highest set bit) and a population count.
// Helpers work on a fixed 64-bit mask; callers zero-extend narrower lists.
package reglist_pkg;

    localparam int MAXW  = 64;
    localparam int MAXIW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [MAXIW-1:0] pri_lo(input logic [MAXW-1:0] mask);
        logic [MAXIW-1:0] r;
        r = '0;
        for (int i = MAXW - 1; i >= 0; i--) begin
            if (mask[i]) r = MAXIW'(i);
        end
        return r;
    endfunction

    // Index of the highest set bit; 0 when the mask is empty.
    function automatic logic [MAXIW-1:0] pri_hi(input logic [MAXW-1:0] mask);
        logic [MAXIW-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (mask[i]) r = MAXIW'(i);
        end
        return r;
    endfunction

    function automatic logic [MAXIW:0] popcnt(input logic [MAXW-1:0] mask);
        logic [MAXIW:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++) begin
            r = r + {{MAXIW{1'b0}}, mask[i]};
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
module decoder_onehot #(
    parameter int W = 4
) (
    input  logic [W-1:0]        idx,
    input  logic                en,
    output logic [(1<<W)-1:0]   onehot
);

    // Decode idx to a single set bit, gated by en.
    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/reglist_sequencer.sv
// Register-list sequencer for block transfers: captures a register list and
// emits one register per accepted beat (index + one-hot), ascending or
// descending, with a ready/valid handshake and a transfer count.
//
//   state | meaning
//   IDLE  | waiting for start; outputs quiet
//   RUN   | presenting beats, advancing on valid & ready
//   DONE  | one-cycle done pulse, then back to IDLE
module reglist_sequencer
    import reglist_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int IDXW  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NREGS-1:0]  reg_list,
    input  logic              up,
    input  logic              flush,
    input  logic              ready,
    output logic              valid,
    output logic [IDXW-1:0]   idx,
    output logic [NREGS-1:0]  onehot,
    output logic              last,
    output logic [IDXW:0]     count,
    output logic              busy,
    output logic              done
);

    state_t             state;
    logic [NREGS-1:0]   pending;
    logic [NREGS-1:0]   pending_nxt;
    logic               dir;
    logic [IDXW-1:0]    first_idx;
    logic [IDXW-1:0]    next_idx;
    logic [IDXW:0]      list_cnt;
    logic               next_one;

    // Selection for the first beat of a new list and for the beat following
    // the one currently presented (current bit removed from pending).
    always_comb begin
        pending_nxt = pending & ~(NREGS'(1) << idx);
        list_cnt    = (IDXW+1)'(popcnt(MAXW'(reg_list)));
        first_idx   = up  ? IDXW'(pri_lo(MAXW'(reg_list)))
                          : IDXW'(pri_hi(MAXW'(reg_list)));
        next_idx    = dir ? IDXW'(pri_lo(MAXW'(pending_nxt)))
                          : IDXW'(pri_hi(MAXW'(pending_nxt)));
        next_one    = (popcnt(MAXW'(pending_nxt)) == (MAXIW+1)'(1));
    end

    // Sequencer state, pending mask and registered outputs; flush beats start/ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            dir     <= 1'b0;
            valid   <= 1'b0;
            idx     <= '0;
            last    <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            pending <= '0;
            valid   <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pending <= reg_list;
                        dir     <= up;
                        count   <= list_cnt;
                        busy    <= 1'b1;
                        if (|reg_list) begin
                            state <= RUN;
                            valid <= 1'b1;
                            idx   <= first_idx;
                            last  <= (list_cnt == (IDXW+1)'(1));
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (ready) begin
                        if (last) begin
                            state   <= DONE;
                            pending <= '0;
                            valid   <= 1'b0;
                            last    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            pending <= pending_nxt;
                            idx     <= next_idx;
                            last    <= next_one;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    last  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    decoder_onehot #(.W(IDXW)) u_dec (
        .idx    (idx),
        .en     (valid),
        .onehot (onehot)
    );

endmodule

// File: tb/tb_reglist_sequencer.sv
// Bench for reglist_sequencer: directed scenarios plus randomized lists,
// directions and ready patterns, checked against a queue-based model of the
// expected beat order. Drives on the falling edge, samples on the falling edge.
module tb_reglist_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start16, start8, up, flush, ready;
    logic [15:0] reg_list;

    logic        v16, l16, b16, d16;
    logic [3:0]  i16;
    logic [15:0] oh16;
    logic [4:0]  c16;

    logic        v8, l8, b8, d8;
    logic [2:0]  i8;
    logic [7:0]  oh8;
    logic [3:0]  c8;

    int n_chk = 0;
    int n_err = 0;
    bit sel8 = 1'b0;

    logic        o_valid, o_last, o_busy, o_done;
    logic [15:0] o_idx, o_onehot, o_count;

    always #5 clk = ~clk;

    reglist_sequencer #(.NREGS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .reg_list(reg_list), .up(up),
        .flush(flush), .ready(ready), .valid(v16), .idx(i16), .onehot(oh16),
        .last(l16), .count(c16), .busy(b16), .done(d16)
    );

    reglist_sequencer #(.NREGS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .reg_list(reg_list[7:0]), .up(up),
        .flush(flush), .ready(ready), .valid(v8), .idx(i8), .onehot(oh8),
        .last(l8), .count(c8), .busy(b8), .done(d8)
    );

    always_comb begin
        if (sel8) begin
            o_valid = v8;  o_last = l8;  o_busy = b8;  o_done = d8;
            o_idx = {13'd0, i8}; o_onehot = {8'd0, oh8}; o_count = {12'd0, c8};
        end else begin
            o_valid = v16; o_last = l16; o_busy = b16; o_done = d16;
            o_idx = {12'd0, i16}; o_onehot = oh16; o_count = {11'd0, c16};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one list from start to idle. Called right after a falling edge.
    task automatic run_seq(input bit w8, input logic [15:0] lst, input logic dir,
                           input logic [63:0] rpat, input bit noise);
        int q[$];
        int n;
        int cyc;
        int nb;
        logic rdy;
        nb = w8 ? 8 : 16;
        sel8 = w8;
        for (int i = 0; i < nb; i++) begin
            if (lst[i]) begin
                if (dir) q.push_back(i);
                else     q.push_front(i);
            end
        end
        n = q.size();
        reg_list = lst;
        up       = dir;
        start16  = !w8;
        start8   = w8;
        @(negedge clk);
        start16 = 1'b0;
        start8  = 1'b0;
        chk("count", o_count, n);
        chk("busy_run", o_busy, 1);
        cyc = 0;
        while (q.size() > 0 && cyc < 300) begin
            chk("valid", o_valid, 1);
            chk("idx", o_idx, q[0]);
            chk("onehot", o_onehot, 64'(1) << q[0]);
            chk("last", o_last, (q.size() == 1) ? 1 : 0);
            chk("no_done", o_done, 0);
            rdy   = rpat[cyc % 64];
            ready = rdy;
            if (noise) begin
                start16  = !w8 && ($urandom_range(0, 2) == 0);
                start8   = w8 && ($urandom_range(0, 2) == 0);
                reg_list = 16'($urandom);
                up       = 1'($urandom);
            end
            @(negedge clk);
            if (rdy) void'(q.pop_front());
            cyc++;
        end
        chk("beats_left", q.size(), 0);
        chk("end_valid", o_valid, 0);
        chk("end_onehot", o_onehot, 0);
        chk("done", o_done, 1);
        chk("busy_done", o_busy, 1);
        chk("count_hold", o_count, n);
        // start during the DONE cycle must be ignored
        reg_list = 16'h00FF;
        start16  = !w8;
        start8   = w8;
        @(negedge clk);
        start16 = 1'b0;
        start8  = 1'b0;
        chk("done_pulse", o_done, 0);
        chk("busy_idle", o_busy, 0);
        chk("idle_valid", o_valid, 0);
        @(negedge clk);
        chk("still_idle", o_busy, 0);
        chk("still_idle_valid", o_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lst;
        logic [63:0] rp;
        bit          w8;
        rst_n = 1'b0; start16 = 1'b0; start8 = 1'b0; up = 1'b0;
        flush = 1'b0; ready = 1'b0; reg_list = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", v16, 0);  chk("rst_idx", i16, 0);  chk("rst_onehot", oh16, 0);
        chk("rst_last", l16, 0);   chk("rst_count", c16, 0); chk("rst_busy", b16, 0);
        chk("rst_done", d16, 0);   chk("rst8_valid", v8, 0); chk("rst8_busy", b8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed scenarios
        run_seq(0, 16'h8001, 1, '1, 0);
        run_seq(0, 16'h00F0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 0);
        run_seq(0, 16'h0000, 1, '1, 0);
        run_seq(0, 16'hFFFF, 1, '1, 1);
        run_seq(1, 16'h00A5, 0, '1, 0);

        // flush during the third beat of 0x0F0F
        sel8 = 1'b0;
        reg_list = 16'h0F0F; up = 1'b1; ready = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("fl_idx3", o_idx, 2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid", o_valid, 0);
        chk("fl_busy", o_busy, 0);
        chk("fl_done", o_done, 0);
        chk("fl_last", o_last, 0);
        chk("fl_onehot", o_onehot, 0);
        chk("fl_count", o_count, 8);
        @(negedge clk);
        chk("fl_nodone", o_done, 0);
        run_seq(0, 16'h0002, 1, '1, 0);

        // flush wins over start in IDLE
        reg_list = 16'h00F0; start16 = 1'b1; flush = 1'b1;
        @(negedge clk);
        start16 = 1'b0; flush = 1'b0;
        chk("fl_start_busy", o_busy, 0);
        chk("fl_start_valid", o_valid, 0);

        // reset mid-sequence
        reg_list = 16'h00FF; up = 1'b0; ready = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        chk("pre_rst_idx", o_idx, 6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_valid", o_valid, 0); chk("mrst_idx", o_idx, 0);
        chk("mrst_onehot", o_onehot, 0); chk("mrst_last", o_last, 0);
        chk("mrst_count", o_count, 0); chk("mrst_busy", o_busy, 0);
        chk("mrst_done", o_done, 0);
        @(negedge clk);
        chk("mrst_nodone", o_done, 0);
        chk("mrst_idle", o_busy, 0);

        // randomized lists, directions and ready patterns
        for (int t = 0; t < 24; t++) begin
            w8 = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       lst = 16'h0000;
                1:       lst = 16'hFFFF;
                2:       lst = 16'(1) << $urandom_range(0, 15);
                default: lst = 16'($urandom);
            endcase
            if (w8) lst = lst & 16'h00FF;
            rp = {$urandom, $urandom};
            run_seq(w8, lst, 1'($urandom), rp, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
